// File: rtl/apple2_kbd_decoder.sv
// apple2_kbd_decoder
// Converts MiSTer PS/2 key events into the Apple II+ keyboard register.
// Tracks the shift/ctrl modifiers and maps scancodes to uppercase-only ASCII.
// A mapped make latches the character with strobe bit 7 set. A CPU access
// to $C010 clears that strobe.
//
// Ports:
//   CLK_14M  in   master clock; all logic runs on its rising edge
//   reset    in   asynchronous, active-high reset
//   PS2_Key  in   [10] event toggle, [9] make(1)/break(0), [8] E0 prefix,
//                 [7:0] scancode
//   reads    in   one-cycle pulse when the CPU touches $C010
//   K        out  [7] strobe, [6:0] ASCII of the last mapped key
//   akd      out  high while the key that produced K is held down
//
// Latency: the toggle change is sampled on edge A, which registers ev_q
// and ev_key. The lookup is combinational from those registers, and K/akd
// are written on edge B.

module apple2_kbd_decoder (
  input  logic        CLK_14M,
  input  logic        reset,
  input  logic [10:0] PS2_Key,
  input  logic        reads,
  output logic [7:0]  K,
  output logic        akd
);

  logic       tog_q;
  logic       armed;
  logic       ev_q;
  logic [9:0] ev_key;
  logic       lshift;
  logic       rshift;
  logic       ctrl;
  logic [8:0] held;

  logic       ev;
  logic       mapped;
  logic [6:0] base;
  logic [6:0] ascii;
  logic       shift;

  // The first clock after reset only loads tog_q, so a toggle level that
  // was held through reset is never mistaken for an event.
  assign ev    = armed && (tog_q != PS2_Key[10]);
  assign shift = lshift | rshift;

  always_comb begin
    base   = 7'h00;
    mapped = 1'b1;
    if (ev_key[8]) begin
      case (ev_key[7:0])
        8'h6B:   base = 7'h08;
        8'h74:   base = 7'h15;
        8'h75:   base = 7'h0B;
        8'h72:   base = 7'h0A;
        default: mapped = 1'b0;
      endcase
    end else begin
      case (ev_key[7:0])
        8'h1C: base = 7'h41;  8'h32: base = 7'h42;  8'h21: base = 7'h43;
        8'h23: base = 7'h44;  8'h24: base = 7'h45;  8'h2B: base = 7'h46;
        8'h34: base = 7'h47;  8'h33: base = 7'h48;  8'h43: base = 7'h49;
        8'h3B: base = 7'h4A;  8'h42: base = 7'h4B;  8'h4B: base = 7'h4C;
        8'h3A: base = 7'h4D;  8'h31: base = 7'h4E;  8'h44: base = 7'h4F;
        8'h4D: base = 7'h50;  8'h15: base = 7'h51;  8'h2D: base = 7'h52;
        8'h1B: base = 7'h53;  8'h2C: base = 7'h54;  8'h3C: base = 7'h55;
        8'h2A: base = 7'h56;  8'h1D: base = 7'h57;  8'h22: base = 7'h58;
        8'h35: base = 7'h59;  8'h1A: base = 7'h5A;
        8'h16: base = shift ? 7'h21 : 7'h31;
        8'h1E: base = shift ? 7'h40 : 7'h32;
        8'h26: base = shift ? 7'h23 : 7'h33;
        8'h25: base = shift ? 7'h24 : 7'h34;
        8'h2E: base = shift ? 7'h25 : 7'h35;
        8'h36: base = shift ? 7'h5E : 7'h36;
        8'h3D: base = shift ? 7'h26 : 7'h37;
        8'h3E: base = shift ? 7'h2A : 7'h38;
        8'h46: base = shift ? 7'h28 : 7'h39;
        8'h45: base = shift ? 7'h29 : 7'h30;
        8'h41: base = shift ? 7'h3C : 7'h2C;
        8'h4E: base = shift ? 7'h5F : 7'h2D;
        8'h49: base = shift ? 7'h3E : 7'h2E;
        8'h4A: base = shift ? 7'h3F : 7'h2F;
        8'h4C: base = shift ? 7'h3A : 7'h3B;
        8'h52: base = shift ? 7'h22 : 7'h27;
        8'h55: base = shift ? 7'h2B : 7'h3D;
        8'h54: base = shift ? 7'h7B : 7'h5B;
        8'h5B: base = shift ? 7'h7D : 7'h5D;
        8'h5D: base = shift ? 7'h7C : 7'h5C;
        8'h0E: base = shift ? 7'h7E : 7'h60;
        8'h5A: base = 7'h0D;
        8'h66: base = 7'h08;
        8'h0D: base = 7'h09;
        8'h76: base = 7'h1B;
        8'h29: base = 7'h20;
        default: mapped = 1'b0;
      endcase
    end
  end

  // Only letters land in 0x41-0x5A. Shifted digits and brackets fall
  // outside that range, so ctrl leaves them alone.
  always_comb begin
    ascii = base;
    if (ctrl && (base >= 7'h41) && (base <= 7'h5A))
      ascii = base & 7'h1F;
  end

  always_ff @(posedge CLK_14M or posedge reset) begin
    if (reset) begin
      tog_q  <= 1'b0;
      armed  <= 1'b0;
      ev_q   <= 1'b0;
      ev_key <= 10'h000;
    end else begin
      tog_q <= PS2_Key[10];
      armed <= 1'b1;
      ev_q  <= ev;
      if (ev)
        ev_key <= PS2_Key[9:0];
    end
  end

  always_ff @(posedge CLK_14M or posedge reset) begin
    if (reset) begin
      lshift <= 1'b0;
      rshift <= 1'b0;
      ctrl   <= 1'b0;
    end else if (ev_q) begin
      if (ev_key[8:0] == 9'h012) lshift <= ev_key[9];
      if (ev_key[8:0] == 9'h059) rshift <= ev_key[9];
      if (ev_key[7:0] == 8'h14)  ctrl   <= ev_key[9];
    end
  end

  // A mapped write is placed after the reads clear, so a new key that
  // lands in the same cycle as a reads pulse keeps its strobe.
  always_ff @(posedge CLK_14M or posedge reset) begin
    if (reset) begin
      K    <= 8'h00;
      akd  <= 1'b0;
      held <= 9'h000;
    end else begin
      if (reads)
        K[7] <= 1'b0;
      if (ev_q && ev_key[9] && mapped) begin
        K    <= {1'b1, ascii};
        akd  <= 1'b1;
        held <= ev_key[8:0];
      end else if (ev_q && !ev_key[9] && (ev_key[8:0] == held)) begin
        akd <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_apple2_kbd_decoder.sv
module tb_apple2_kbd_decoder;

  logic        clk;
  logic        reset;
  logic [10:0] ps2_key;
  logic        reads;
  logic [7:0]  k;
  logic        akd;

  int n_vec = 0;
  int n_bad = 0;

  logic [8:0] sb_q[$];

  apple2_kbd_decoder dut (
    .CLK_14M (clk),
    .reset   (reset),
    .PS2_Key (ps2_key),
    .reads   (reads),
    .K       (k),
    .akd     (akd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ev(input logic mk, input logic ext, input logic [7:0] code);
    ps2_key = {~ps2_key[10], mk, ext, code};
  endtask

  task automatic pop_chk(input string tag);
    logic [8:0] e;
    if (sb_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: scoreboard empty got %h want entry", tag, k);
    end else begin
      e = sb_q.pop_front();
      chk({tag, ".k"}, {24'h0, k}, {24'h0, e[8:1]});
      chk({tag, ".akd"}, {31'h0, akd}, {31'h0, e[0]});
    end
  endtask

  // Each event: push the expected result, toggle, wait for writeback, compare.
  task automatic ev(input string tag, input logic mk, input logic ext, input logic [7:0] code,
                    input logic [7:0] ek, input logic ea);
    sb_q.push_back({ek, ea});
    drive_ev(mk, ext, code);
    tick();
    tick();
    pop_chk(tag);
    tick();
  endtask

  string letters = "ABCDEFGHIJKLMNOPQRSTUVWXYZ";
  logic [7:0] letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                 8'h35, 8'h1A};
  logic [7:0] digit_sc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                8'h3E, 8'h46};
  string digit_sh = ")!@#$%^&*(";

  initial begin
    reset   = 1'b1;
    ps2_key = 11'h400;
    reads   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.k", {24'h0, k}, 32'h00);
    chk("rst.akd", {31'h0, akd}, 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("arm.k", {24'h0, k}, 32'h00);
      chk("arm.akd", {31'h0, akd}, 32'h0);
    end

    ev("make_a", 1, 0, 8'h1C, 8'hC1, 1);
    reads = 1'b1;
    tick();
    reads = 1'b0;
    chk("read.k", {24'h0, k}, 32'h41);
    chk("read.akd", {31'h0, akd}, 32'h1);
    ev("brk_a", 0, 0, 8'h1C, 8'h41, 0);

    ev("lshift_mk", 1, 0, 8'h12, 8'h41, 0);
    ev("sh_2", 1, 0, 8'h1E, 8'hC0, 1);
    ev("lshift_brk", 0, 0, 8'h12, 8'hC0, 1);
    ev("ctrl_mk", 1, 0, 8'h14, 8'hC0, 1);
    ev("ctrl_c", 1, 0, 8'h21, 8'h83, 1);
    ev("ctrl_1", 1, 0, 8'h16, 8'hB1, 1);
    ev("ctrl_brk", 0, 0, 8'h14, 8'hB1, 1);
    ev("ectrl_mk", 1, 1, 8'h14, 8'hB1, 1);
    ev("ectrl_d", 1, 0, 8'h23, 8'h84, 1);
    ev("ectrl_brk", 0, 1, 8'h14, 8'h84, 1);
    ev("plain_6", 1, 0, 8'h36, 8'hB6, 1);
    ev("rshift_mk", 1, 0, 8'h59, 8'hB6, 1);
    ev("sh_6", 1, 0, 8'h36, 8'hDE, 1);
    ev("sh_comma", 1, 0, 8'h41, 8'hBC, 1);
    ev("sh_a", 1, 0, 8'h1C, 8'hC1, 1);
    ev("rshift_brk", 0, 0, 8'h59, 8'hC1, 1);
    ev("comma", 1, 0, 8'h41, 8'hAC, 1);

    ev("e_left", 1, 1, 8'h6B, 8'h88, 1);
    ev("f1", 1, 0, 8'h05, 8'h88, 1);
    ev("e_right", 1, 1, 8'h74, 8'h95, 1);
    ev("e_up", 1, 1, 8'h75, 8'h8B, 1);
    ev("e_down", 1, 1, 8'h72, 8'h8A, 1);
    ev("enter", 1, 0, 8'h5A, 8'h8D, 1);
    ev("e_5a", 1, 1, 8'h5A, 8'h8D, 1);
    ev("bksp", 1, 0, 8'h66, 8'h88, 1);
    ev("tab", 1, 0, 8'h0D, 8'h89, 1);
    ev("esc", 1, 0, 8'h76, 8'h9B, 1);
    ev("brk_esc", 0, 0, 8'h76, 8'h9B, 0);
    ev("f1_brk", 0, 0, 8'h05, 8'h9B, 0);

    ev("hold_a", 1, 0, 8'h1C, 8'hC1, 1);
    ev("hold_b", 1, 0, 8'h32, 8'hC2, 1);
    ev("hold_brk_a", 0, 0, 8'h1C, 8'hC2, 1);
    ev("hold_brk_b", 0, 0, 8'h32, 8'hC2, 0);

    for (int i = 0; i < 26; i++) begin
      logic [7:0] asc;
      asc = letters[i];
      ev("letter", 1, 0, letter_sc[i], {1'b1, asc[6:0]}, 1);
      ev("letter_brk", 0, 0, letter_sc[i], {1'b1, asc[6:0]}, 0);
    end
    for (int i = 0; i < 10; i++) begin
      logic [7:0] asc;
      asc = 8'h30 + 8'(i);
      ev("digit", 1, 0, digit_sc[i], {1'b1, asc[6:0]}, 1);
    end
    ev("dig_shift", 1, 0, 8'h12, 8'hB9, 1);
    for (int i = 0; i < 10; i++) begin
      logic [7:0] asc;
      asc = digit_sh[i];
      ev("digit_sh", 1, 0, digit_sc[i], {1'b1, asc[6:0]}, 1);
    end
    ev("dig_unshift", 0, 0, 8'h12, 8'hA8, 1);

    // reads lands on the same edge as the space writeback
    sb_q.push_back({8'hA0, 1'b1});
    drive_ev(1, 0, 8'h29);
    tick();
    reads = 1'b1;
    tick();
    reads = 1'b0;
    pop_chk("collide");
    tick();
    reads = 1'b1;
    tick();
    reads = 1'b0;
    chk("read2.k", {24'h0, k}, 32'h20);
    chk("read2.akd", {31'h0, akd}, 32'h1);
    ev("repeat", 1, 0, 8'h29, 8'hA0, 1);

    drive_ev(1, 0, 8'h1C);
    tick();
    reset = 1'b1;
    #1;
    chk("midrst.k", {24'h0, k}, 32'h00);
    chk("midrst.akd", {31'h0, akd}, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    repeat (4) tick();
    chk("late.k", {24'h0, k}, 32'h00);
    chk("late.akd", {31'h0, akd}, 32'h0);
    ev("post_rst", 1, 0, 8'h32, 8'hC2, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
